bar_decode_fifo: RTL and testbench

BAR_DECODE_FIFO -- requirements
Module: bar_decode_fifo

---
 rtl/bar_decode_fifo.sv | 68 ++++++
 tb/tb_bar_decode_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bar_decode_fifo.sv
// bar_decode_fifo: checks and decodes Bar words and queues their payloads in a FIFO with a saturating error counter.
// Define BAR_DECODE_DROP_BAD_EN to count malformed words without enqueuing them.
module bar_decode_fifo #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [5:0]       out_data,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [5:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [5:0]       last_q, last_d;
    logic             accept, bad, wr, pop;

    always_comb begin
        in_ready  = cnt_q != FULL;
        out_valid = cnt_q != '0;
        out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;
        err_count = err_q;
        accept    = in_valid && in_ready;
        bad       = !(in_data[2:0] == 3'b000 || in_data[2:0] == 3'b111);
`ifdef BAR_DECODE_DROP_BAD_EN
        wr        = accept && !bad;
`else
        wr        = accept;
`endif
        pop       = out_valid && out_ready;
        wr_ptr_d  = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        // Saturate rather than wrap once all ones.
        err_d     = (accept && bad && !(&err_q)) ? err_q + 1'b1 : err_q;
        last_d    = pop ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr) mem_q[wr_ptr_q] <= in_data[7:2];
    end
endmodule

// File: tb/tb_bar_decode_fifo.sv
// tb_bar_decode_fifo: scoreboard bench for bar_decode_fifo; a second ERR_W=2 instance covers counter saturation.
module tb_bar_decode_fifo;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, out_valid;
    logic [5:0] out_data;
    logic [7:0] err_count;

    logic       b_valid = 1'b0, b_oready = 1'b1;
    logic [7:0] b_data = '0;
    logic       b_iready, b_ovalid;
    logic [5:0] b_odata;
    logic [1:0] b_err;

    logic [5:0] exp_q[$];
    int         exp_err = 0;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    bar_decode_fifo #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .CLK(clk), .ASYNCRESETN(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .err_count(err_count));

    bar_decode_fifo #(.DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .CLK(clk), .ASYNCRESETN(rst_n), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_iready), .out_valid(b_ovalid), .out_data(b_odata),
        .out_ready(b_oready), .err_count(b_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic bit malformed(input logic [7:0] d);
        return !(d[2:0] == 3'b000 || d[2:0] == 3'b111);
    endfunction

    // Drive one cycle at the falling edge, check state-derived outputs against the model, then advance the model.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        bit m_ready, m_valid;
        @(negedge clk);
        in_valid = v;
        in_data = d;
        out_ready = r;
        m_ready = exp_q.size() < DEPTH;
        m_valid = exp_q.size() != 0;
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        check("err_count", err_count, exp_err);
        if (m_valid) check("out_data", out_data, exp_q[0]);
        if (m_valid && r) void'(exp_q.pop_front());
        if (v && m_ready) begin
            if (malformed(d) && exp_err < 255) exp_err++;
`ifdef BAR_DECODE_DROP_BAD_EN
            if (!malformed(d)) exp_q.push_back(d[7:2]);
`else
            exp_q.push_back(d[7:2]);
`endif
        end
    endtask

    initial begin
        logic [7:0] full_words[5];
        int sat_exp[5];
        full_words = '{8'h03, 8'h07, 8'h08, 8'h1F, 8'h20};
        sat_exp = '{1, 2, 3, 3, 3};
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_err", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic
        cyc(1, 8'h17, 1);
        cyc(1, 8'h10, 1);
        repeat (3) cyc(0, 8'h00, 1);
        // full: four accepted, fifth held until space frees
        for (int i = 0; i < 4; i++) cyc(1, full_words[i], 0);
        repeat (3) cyc(1, full_words[4], 0);
        // simultaneous: pop only when full, then accept+pop together
        cyc(1, full_words[4], 1);
        cyc(1, 8'h2F, 1);
        cyc(0, 8'h00, 0);
        repeat (6) cyc(0, 8'h00, 1);
        // malformed
        cyc(1, 8'h12, 0);
        repeat (3) cyc(0, 8'h00, 1);
        // randomised traffic
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        repeat (6) cyc(0, 8'h00, 1);

        // saturation on the ERR_W=2 instance
        @(negedge clk);
        b_valid = 1'b1;
        b_data = 8'h12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sat_err", b_err, sat_exp[i]);
        end
        b_valid = 1'b0;

        // reset mid-operation with three entries and a nonzero error count
        cyc(1, 8'h12, 0);
        cyc(1, 8'h27, 0);
        cyc(1, 8'h38, 0);
        cyc(0, 8'h00, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err", err_count, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_sat_err", b_err, 0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_err = 0;
        repeat (3) cyc(0, 8'h00, 1);
        cyc(1, 8'h0F, 1);
        repeat (3) cyc(0, 8'h00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
